// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave bridging command/address/data transactions onto a byte-wide synchronous frame memory.
// Define SPI_STATUS_CMD_EN to accept the CMD_STATUS opcode and keep overrun/last-write/wrap flags.
module spi_mem_bridge #(
  parameter int         ADDR_W     = 17,
  parameter int         ADDR_BYTES = 3,
  parameter int         DATA_W     = 8,
  parameter logic [7:0] CMD_READ   = 8'h03,
  parameter logic [7:0] CMD_WRITE  = 8'h02,
  parameter logic [7:0] CMD_STATUS = 8'h05
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ssel,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy
);

  localparam int ACC_W  = 8 * ADDR_BYTES;
  localparam int ACNT_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  if (DATA_W != 8) begin : g_bad_data_w
    $error("spi_mem_bridge: DATA_W must be 8");
  end
  if (ADDR_W > ACC_W) begin : g_bad_addr_w
    $error("spi_mem_bridge: ADDR_W exceeds 8*ADDR_BYTES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_DISCARD, S_STAT
  } state_t;

`ifdef SPI_STATUS_CMD_EN
  localparam bit L_STAT_EN = 1'b1;
`else
  localparam bit L_STAT_EN = 1'b0;
`endif

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_sclk_s, r_mosi_s, r_ssel_s;
  logic                r_sclk_d, r_ssel_d;
  logic [2:0]          r_bit_cnt;
  logic [6:0]          r_rx;
  logic [7:0]          r_tx;
  logic [ACC_W-1:0]    r_acc;
  logic [ACNT_W-1:0]   r_abyte_cnt;
  logic                r_is_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_mem_rd, r_mem_wr, r_rd_vld;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_first, r_skip;
  logic [7:0]          r_pf;
  logic                r_pf_vld;

  logic                w_rise, w_fall, w_ssel_fall, w_ssel_rise, w_byte_done, w_bnd;
  logic [7:0]          w_rx_byte, w_status;
  logic [ACC_W-1:0]    w_acc_next;
  logic                w_last_abyte, w_cmd_rw, w_cmd_is_stat;
  logic                w_rd_req, w_wr_req, w_first_ret, w_pf_ret, w_bnd_load;
  logic                w_addr_inc, w_stat_load, w_skip_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_s <= 2'b00;
      r_sclk_d <= 1'b0;
      r_mosi_s <= 2'b00;
      r_ssel_s <= 2'b11;
      r_ssel_d <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_sclk_d <= r_sclk_s[1];
      r_mosi_s <= {r_mosi_s[0], mosi};
      r_ssel_s <= {r_ssel_s[0], ssel};
      r_ssel_d <= r_ssel_s[1];
    end
  end

  assign w_rise        = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall        = ~r_sclk_s[1] & r_sclk_d;
  assign w_ssel_fall   = ~r_ssel_s[1] & r_ssel_d;
  assign w_ssel_rise   = r_ssel_s[1] & ~r_ssel_d;
  assign w_byte_done   = w_rise && (r_bit_cnt == 3'd7);
  assign w_bnd         = w_fall && (r_bit_cnt == 3'd0);
  assign w_rx_byte     = {r_rx, r_mosi_s[1]};
  assign w_acc_next    = (r_acc << 8) | ACC_W'(w_rx_byte);
  assign w_last_abyte  = (r_abyte_cnt == ACNT_W'(ADDR_BYTES - 1));
  assign w_cmd_rw      = (w_rx_byte == CMD_READ) || (w_rx_byte == CMD_WRITE);
  assign w_cmd_is_stat = (w_rx_byte == CMD_STATUS);
  assign w_skip_clr    = w_bnd && r_skip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ssel_fall) w_state_nxt = S_CMD;
      S_CMD:   if (w_byte_done) begin
                 if (w_cmd_rw)                       w_state_nxt = S_ADDR;
                 else if (w_cmd_is_stat && L_STAT_EN) w_state_nxt = S_STAT;
                 else                                w_state_nxt = S_DISCARD;
               end
      S_ADDR:  if (w_byte_done && w_last_abyte) w_state_nxt = r_is_wr ? S_WDATA : S_RDATA;
      S_STAT:  if (w_byte_done) w_state_nxt = S_DISCARD;
      default: ;
    endcase
    if (w_ssel_rise) w_state_nxt = S_IDLE;
  end

  // Write-address increment lands the cycle after the mem_wr strobe, in whatever state follows.
  always_comb begin
    w_rd_req    = 1'b0;
    w_wr_req    = 1'b0;
    w_first_ret = 1'b0;
    w_pf_ret    = 1'b0;
    w_bnd_load  = 1'b0;
    w_addr_inc  = r_mem_wr;
    w_stat_load = 1'b0;
    case (r_state)
      S_CMD:   w_stat_load = L_STAT_EN && w_byte_done && w_cmd_is_stat;
      S_ADDR:  w_rd_req = w_byte_done && w_last_abyte && !r_is_wr && !w_ssel_rise;
      S_RDATA: if (!w_ssel_rise) begin
                 if (r_rd_vld && r_first) begin
                   w_first_ret = 1'b1;
                   w_rd_req    = 1'b1;
                   w_addr_inc  = 1'b1;
                 end else if (r_rd_vld) begin
                   w_pf_ret = 1'b1;
                 end
                 if (w_bnd && !r_skip && !r_first) begin
                   w_bnd_load = 1'b1;
                   w_rd_req   = 1'b1;
                   w_addr_inc = 1'b1;
                 end
               end
      S_WDATA: w_wr_req = w_byte_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'd0;
      r_acc       <= '0;
      r_abyte_cnt <= '0;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_wdata     <= '0;
      r_first     <= 1'b0;
      r_skip      <= 1'b0;
      r_pf        <= 8'd0;
      r_pf_vld    <= 1'b0;
    end else begin
      r_mem_rd <= w_rd_req;
      r_mem_wr <= w_wr_req;
      r_rd_vld <= r_mem_rd;
      if (w_wr_req) r_wdata <= w_rx_byte;

      if (r_state == S_IDLE) begin
        r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
        r_rx      <= w_rx_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (r_state == S_CMD && w_byte_done) begin
        r_is_wr     <= (w_rx_byte == CMD_WRITE);
        r_abyte_cnt <= '0;
      end

      if (r_state == S_ADDR && w_byte_done) begin
        r_acc       <= w_acc_next;
        r_abyte_cnt <= r_abyte_cnt + ACNT_W'(1);
        if (w_last_abyte) r_addr <= w_acc_next[ADDR_W-1:0];
      end else if (w_addr_inc) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      // A freshly loaded byte already has its MSB on miso, so its first falling edge must not shift.
      if (r_state == S_IDLE || r_state == S_DISCARD) r_tx <= 8'd0;
      else if (w_first_ret)                          r_tx <= mem_rdata;
      else if (w_bnd_load)                           r_tx <= r_pf_vld ? r_pf : 8'd0;
      else if (w_stat_load)                          r_tx <= w_status;
      else if (w_fall && !w_skip_clr)                r_tx <= {r_tx[6:0], 1'b0};

      if (r_state == S_IDLE)               r_skip <= 1'b0;
      else if (w_first_ret || w_stat_load) r_skip <= 1'b1;
      else if (w_skip_clr)                 r_skip <= 1'b0;

      if (r_state == S_IDLE)                    r_first <= 1'b0;
      else if (r_state == S_ADDR && w_rd_req)   r_first <= 1'b1;
      else if (w_first_ret)                     r_first <= 1'b0;

      if (r_state == S_IDLE || (r_state == S_ADDR && w_rd_req)) begin
        r_pf_vld <= 1'b0;
      end else begin
        if (w_bnd_load) r_pf_vld <= 1'b0;
        if (w_pf_ret) begin
          r_pf     <= mem_rdata;
          r_pf_vld <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_STATUS_CMD_EN
  logic r_ovr, r_lww, r_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovr  <= 1'b0;
      r_lww  <= 1'b0;
      r_wrap <= 1'b0;
    end else if (r_state == S_STAT && w_byte_done) begin
      r_ovr  <= 1'b0;
      r_lww  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (w_bnd_load && !r_pf_vld)               r_ovr  <= 1'b1;
      if (w_addr_inc && (&r_addr))               r_wrap <= 1'b1;
      if (r_state == S_CMD && w_byte_done && w_cmd_rw) r_lww <= (w_rx_byte == CMD_WRITE);
    end
  end

  assign w_status = {5'b00000, r_ovr, r_lww, r_wrap};
`else
  assign w_status = 8'h00;
`endif

  assign miso      = r_tx[7];
  assign mem_addr  = r_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_wdata;
  assign busy      = ~r_ssel_s[1];

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Randomised bench for spi_mem_bridge: an SPI master drives transactions and a memory-level
// reference (plain array + address arithmetic) predicts read data, strobe counts and memory contents.
module tb_spi_mem_bridge;
  localparam int MSZ  = 1 << 17;
  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        reset, sclk, mosi, ssel;
  logic        miso, mem_rd, mem_wr, busy;
  logic [16:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;

  spi_mem_bridge dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ssel(ssel), .miso(miso),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [0:MSZ-1];
  logic [7:0] ref_mem [0:MSZ-1];
  logic [7:0] tx_b [0:15];
  logic [7:0] rx_b [0:15];
  logic [7:0] wd   [0:15];
  bit         mem_init_done = 1'b0;
  int         rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int         n_cmp = 0, n_err = 0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 29) ^ (i >> 5) ^ 8'h3C);
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= init_byte(i);
      mem_init_done <= 1'b1;
    end else begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) rd_cnt <= rd_cnt + 1;
      if (mem_wr) wr_cnt <= wr_cnt + 1;
      if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},  32'(miso),      0);
    chk({tag, "_rd"},    32'(mem_rd),    0);
    chk({tag, "_wr"},    32'(mem_wr),    0);
    chk({tag, "_addr"},  32'(mem_addr),  0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_busy"},  32'(busy),      0);
  endtask

  // Mode-0 master. Ends with ssel rising while sclk is still high, so no trailing edge follows the last byte.
  task automatic spi_txn(input int nbytes, input int part_bits, input int rst_bit);
    bit first;
    int bi;
    first = 1'b1;
    bi    = 0;
    for (int b = 0; b < 16; b++) rx_b[b] = 8'h00;
    ssel = 1'b0;
    #(HALF);
    chk("busy_high", 32'(busy), 1);
    for (int b = 0; b <= nbytes; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (b == nbytes && i >= part_bits) break;
        if (!first) sclk = 1'b0;
        first = 1'b0;
        mosi = tx_b[b][7-i];
        #(HALF);
        rx_b[b][7-i] = miso;
        if (bi == rst_bit) begin
          reset = 1'b1;
          #1;
          chk_reset_outputs("midreset");
          ssel = 1'b1;
          sclk = 1'b0;
          mosi = 1'b0;
          #40;
          reset = 1'b0;
          #(2*HALF);
          return;
        end
        sclk = 1'b1;
        #(HALF);
        bi++;
      end
    end
    #(HALF);
    ssel = 1'b1;
    #30;
    chk("busy_low_3clk", 32'(busy), 0);
    #(HALF);
    sclk = 1'b0;
    mosi = 1'b0;
    #(2*HALF);
  endtask

  task automatic set_hdr(input logic [7:0] cmd, input logic [23:0] a24);
    tx_b[0] = cmd;
    tx_b[1] = a24[23:16];
    tx_b[2] = a24[15:8];
    tx_b[3] = a24[7:0];
  endtask

  task automatic do_read(input logic [23:0] a24, input int n);
    int r0, w0, a;
    a = int'(a24[16:0]);
    set_hdr(8'h03, a24);
    for (int k = 0; k < n; k++) tx_b[4+k] = 8'($urandom);
    r0 = rd_cnt;
    w0 = wr_cnt;
    spi_txn(4 + n, 0, -1);
    chk("rd_hdr_miso", {rx_b[0], rx_b[1], rx_b[2], rx_b[3]}, 0);
    for (int k = 0; k < n; k++) chk("rd_data", 32'(rx_b[4+k]), 32'(ref_mem[(a + k) % MSZ]));
    chk("rd_pulses", 32'(rd_cnt - r0), 32'(n + 1));
    chk("rd_no_wr", 32'(wr_cnt - w0), 0);
  endtask

  // Writes wd[0..n-1]; part_bits > 0 appends a truncated extra byte that must be dropped.
  task automatic do_write(input logic [23:0] a24, input int n, input int part_bits);
    int r0, w0, a;
    a = int'(a24[16:0]);
    set_hdr(8'h02, a24);
    for (int k = 0; k < n; k++) tx_b[4+k] = wd[k];
    tx_b[4+n] = 8'($urandom);
    r0 = rd_cnt;
    w0 = wr_cnt;
    spi_txn(4 + n, part_bits, -1);
    for (int k = 0; k < n; k++) ref_mem[(a + k) % MSZ] = wd[k];
    chk("wr_pulses", 32'(wr_cnt - w0), 32'(n));
    chk("wr_no_rd", 32'(rd_cnt - r0), 0);
    for (int k = 0; k <= n; k++)
      chk("wr_mem", 32'(mem[(a + k) % MSZ]), 32'(ref_mem[(a + k) % MSZ]));
    chk("wr_miso_zero", {rx_b[0], rx_b[1], rx_b[4], rx_b[5]}, 0);
  endtask

  task automatic do_discard(input logic [7:0] cmd, input int n);
    int r0, w0;
    tx_b[0] = cmd;
    for (int k = 1; k < n; k++) tx_b[k] = 8'($urandom);
    r0 = rd_cnt;
    w0 = wr_cnt;
    spi_txn(n, 0, -1);
    chk("disc_no_rd", 32'(rd_cnt - r0), 0);
    chk("disc_no_wr", 32'(wr_cnt - w0), 0);
    for (int k = 0; k < n; k++) chk("disc_miso_zero", 32'(rx_b[k]), 0);
  endtask

  task automatic do_status(output logic [7:0] st);
    tx_b[0] = 8'h05;
    tx_b[1] = 8'h00;
    spi_txn(2, 0, -1);
    st = rx_b[1];
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a24;
    logic [7:0]  st;
    int          op, n;

    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);
    reset = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ssel  = 1'b1;
    #23;
    chk_reset_outputs("reset");
    #30;
    reset = 1'b0;
    #(2*HALF);

    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    do_write(24'h000100, 4, 0);
    do_read(24'h000100, 4);

    wd[0] = 8'hAA; wd[1] = 8'hBB; wd[2] = 8'hCC;
    do_write(24'h01FFFE, 3, 0);
    do_read(24'hFFFFFE, 4);

    wd[0] = 8'hA5;
    do_write(24'h000010, 1, 5);

    do_discard(8'h9F, 4);

    set_hdr(8'h03, 24'h000100);
    for (int k = 4; k < 8; k++) tx_b[k] = 8'h00;
    spi_txn(8, 0, 5 * 8 + 3);
    do_read(24'h000000, 2);

`ifndef SPI_STATUS_CMD_EN
    do_discard(8'h05, 2);
`endif

    for (int t = 0; t < 24; t++) begin
      op  = int'($urandom_range(0, 4));
      a24 = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a24[16:0] = 17'(MSZ - int'($urandom_range(1, 3)));
      n = int'($urandom_range(1, 5));
      if (op <= 1) begin
        do_read(a24, n);
      end else if (op <= 3) begin
        for (int k = 0; k < n; k++) wd[k] = 8'($urandom);
        do_write(a24, n, (op == 3) ? int'($urandom_range(1, 7)) : 0);
      end else begin
        tx_b[0] = 8'($urandom);
        while (tx_b[0] == 8'h02 || tx_b[0] == 8'h03 || tx_b[0] == 8'h05) tx_b[0] = 8'($urandom);
        do_discard(tx_b[0], n);
      end
    end

`ifdef SPI_STATUS_CMD_EN
    do_status(st);
    wd[0] = 8'h5A; wd[1] = 8'hC3;
    do_write(24'h01FFFF, 2, 0);
    do_status(st);
    chk("status_after_wrap_write", 32'(st), 32'h03);
    do_status(st);
    chk("status_cleared", 32'(st), 32'h00);
`endif

    chk("rd_wr_overlap", 32'(both_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
